reg_wb_arbiter: RTL and testbench

- Shares the register file's single write port (we3/ad3/wd3) between two write-back requesters: the ALU and the load/store unit (LSU).
- Uses valid/ready handshakes, round-robin arbitration and one registered output stage that drives the register file write port directly.
- Drops x0 writes.
- Exposes an in-flight scoreboard so the decode stage can detect read-after-write hazards against the pending write.

---
 rtl/reg_wb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 32 +++
 rtl/reg_wb_arbiter.sv | 84 ++++++++
 tb/tb_reg_wb_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// The optional forwarding path is enabled with the WB_BYPASS_EN macro.
package reg_wb_pkg;

  localparam int unsigned WB_ADDR_W = 5;
  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned ZERO_REG  = 0;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] ad;
    logic [WB_DATA_W-1:0] wd;
  } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; req[0]/gnt[0] is the ALU, req[1]/gnt[1] the LSU.
module rr_arb2
  import reg_wb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_e last_grant;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == WB_SRC_LSU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant <= WB_SRC_LSU;
    end else if (|gnt) begin
      last_grant <= gnt[0] ? WB_SRC_ALU : WB_SRC_LSU;
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the register-file write port between ALU and LSU write-back with a
// pending-write scoreboard. Define WB_BYPASS_EN to add rd1/rd2 forwarding.
module reg_wb_arbiter
  import reg_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WB_ADDR_W,
  parameter int unsigned DATA_WIDTH = WB_DATA_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [ADDR_WIDTH-1:0] alu_ad_i,
  input  logic [DATA_WIDTH-1:0] alu_wd_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0] lsu_ad_i,
  input  logic [DATA_WIDTH-1:0] lsu_wd_i,
  output logic                  we3_o,
  output logic [ADDR_WIDTH-1:0] ad3_o,
  output logic [DATA_WIDTH-1:0] wd3_o,
  input  logic [ADDR_WIDTH-1:0] chk_ad1_i,
  input  logic [ADDR_WIDTH-1:0] chk_ad2_i,
  output logic                  hazard1_o,
  output logic                  hazard2_o
`ifdef WB_BYPASS_EN
  ,
  input  logic [DATA_WIDTH-1:0] rd1_i,
  input  logic [DATA_WIDTH-1:0] rd2_i,
  output logic [DATA_WIDTH-1:0] rd1_o,
  output logic [DATA_WIDTH-1:0] rd2_o
`endif
);

  logic [1:0]            gnt;
  logic                  hs;
  logic [ADDR_WIDTH-1:0] sel_ad;
  logic [DATA_WIDTH-1:0] sel_wd;

  rr_arb2 u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req    ({lsu_valid_i, alu_valid_i}),
    .gnt    (gnt)
  );

  // The register file takes a write every cycle, so ready is just the grant.
  assign alu_ready_o = gnt[0];
  assign lsu_ready_o = gnt[1];
  assign hs          = |gnt;

  always_comb begin
    sel_ad = alu_ad_i;
    sel_wd = alu_wd_i;
    if (gnt[1]) begin
      sel_ad = lsu_ad_i;
      sel_wd = lsu_wd_i;
    end
  end

  // x0 writes are consumed here but never reach the register file.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we3_o <= 1'b0;
      ad3_o <= '0;
      wd3_o <= '0;
    end else if (hs) begin
      we3_o <= (sel_ad != ADDR_WIDTH'(ZERO_REG));
      ad3_o <= sel_ad;
      wd3_o <= sel_wd;
    end else begin
      we3_o <= 1'b0;
    end
  end

  assign hazard1_o = we3_o & (ad3_o == chk_ad1_i);
  assign hazard2_o = we3_o & (ad3_o == chk_ad2_i);

`ifdef WB_BYPASS_EN
  assign rd1_o = hazard1_o ? wd3_o : rd1_i;
  assign rd2_o = hazard2_o ? wd3_o : rd2_i;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed cases plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_v, lsu_v;
  logic [4:0]  alu_ad, lsu_ad, chk1, chk2;
  logic [31:0] alu_wd, lsu_wd;
  logic        alu_ready, lsu_ready, we3, hz1, hz2;
  logic [4:0]  ad3;
  logic [31:0] wd3;
`ifdef WB_BYPASS_EN
  logic [31:0] rd1_i, rd2_i, rd1_o, rd2_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_wb_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .alu_valid_i (alu_v),
    .alu_ready_o (alu_ready),
    .alu_ad_i    (alu_ad),
    .alu_wd_i    (alu_wd),
    .lsu_valid_i (lsu_v),
    .lsu_ready_o (lsu_ready),
    .lsu_ad_i    (lsu_ad),
    .lsu_wd_i    (lsu_wd),
    .we3_o       (we3),
    .ad3_o       (ad3),
    .wd3_o       (wd3),
    .chk_ad1_i   (chk1),
    .chk_ad2_i   (chk2),
    .hazard1_o   (hz1),
    .hazard2_o   (hz2)
`ifdef WB_BYPASS_EN
    ,
    .rd1_i       (rd1_i),
    .rd2_i       (rd2_i),
    .rd1_o       (rd1_o),
    .rd2_o       (rd2_o)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who wins this cycle, given valids and who won the previous handshake.
  // Returns 0 none, 1 ALU, 2 LSU.
  function automatic int winner(input logic av, input logic lv, input bit last_alu);
    if (av && lv) return last_alu ? 2 : 1;
    if (av) return 1;
    if (lv) return 2;
    return 0;
  endfunction

  bit          m_last_alu;
  logic        m_we;
  logic [4:0]  m_ad;
  logic [31:0] m_wd;
  bit          alu_lost, lsu_lost;
  int          alu_wait, lsu_wait;

  // Transaction model: the accepted request becomes the pending write next cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last_alu = 1'b0;
      m_we = 1'b0; m_ad = '0; m_wd = '0;
      alu_lost = 1'b0; lsu_lost = 1'b0;
      alu_wait = 0; lsu_wait = 0;
    end else begin
      int w;
      w = winner(alu_v, lsu_v, m_last_alu);
      alu_lost = alu_v && (w != 1);
      lsu_lost = lsu_v && (w != 2);
      alu_wait = alu_lost ? alu_wait + 1 : 0;
      lsu_wait = lsu_lost ? lsu_wait + 1 : 0;
      if (w == 1) begin
        m_ad = alu_ad; m_wd = alu_wd; m_we = (alu_ad != 0); m_last_alu = 1'b1;
      end else if (w == 2) begin
        m_ad = lsu_ad; m_wd = lsu_wd; m_we = (lsu_ad != 0); m_last_alu = 1'b0;
      end else begin
        m_we = 1'b0;
      end
    end
  end

  // Compare process: every cycle out of reset, mid-low-phase.
  always @(negedge clk) begin
    if (rst_n) begin
      int w;
      w = winner(alu_v, lsu_v, m_last_alu);
      chk("alu_ready", 32'(alu_ready), 32'(w == 1));
      chk("lsu_ready", 32'(lsu_ready), 32'(w == 2));
      chk("we3", 32'(we3), 32'(m_we));
      chk("ad3", 32'(ad3), 32'(m_ad));
      chk("wd3", wd3, m_wd);
      chk("hazard1", 32'(hz1), 32'(m_we && (m_ad == chk1)));
      chk("hazard2", 32'(hz2), 32'(m_we && (m_ad == chk2)));
      chk("alu_wait", 32'(alu_wait < 2), 32'd1);
      chk("lsu_wait", 32'(lsu_wait < 2), 32'd1);
`ifdef WB_BYPASS_EN
      chk("rd1_o", rd1_o, (m_we && (m_ad == chk1)) ? m_wd : rd1_i);
      chk("rd2_o", rd2_o, (m_we && (m_ad == chk2)) ? m_wd : rd2_i);
`endif
    end
  end

  task automatic set_in(input logic av, input logic [4:0] aad, input logic [31:0] awd,
                        input logic lv, input logic [4:0] lad, input logic [31:0] lwd);
    alu_v = av; alu_ad = aad; alu_wd = awd;
    lsu_v = lv; lsu_ad = lad; lsu_wd = lwd;
  endtask

  // Advance to the next cycle's drive point, then apply inputs.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk1 = 5'd0; chk2 = 5'd0;
`ifdef WB_BYPASS_EN
    rd1_i = 32'h1111_1111; rd2_i = 32'h2222_2222;
`endif
    sample();
    chk("rst_we3", 32'(we3), 32'd0);
    chk("rst_ad3", 32'(ad3), 32'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_hz1", 32'(hz1), 32'd0);
    #2 rst_n = 1'b1;

    // Tie right after reset, held for 6 cycles: strict ALU/LSU alternation.
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      set_in(1'b1, 5'd3, 32'h0000_0A03, 1'b1, 5'd4, 32'h0000_0B04);
      sample();
      chk("tie_alu_ready", 32'(alu_ready), 32'(k % 2 == 0));
      chk("tie_lsu_ready", 32'(lsu_ready), 32'(k % 2 == 1));
      if (k > 0) chk("tie_ad3", 32'(ad3), (k % 2 == 1) ? 32'd3 : 32'd4);
    end

    // Single ALU write, then idle: one-cycle latency, one-cycle we3 pulse.
    next_cycle();
    set_in(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    sample();
    chk("t1_alu_ready", 32'(alu_ready), 32'd1);
    next_cycle();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    sample();
    chk("t1_we3", 32'(we3), 32'd1);
    chk("t1_ad3", 32'(ad3), 32'd5);
    chk("t1_wd3", wd3, 32'hDEAD_BEEF);
    next_cycle();
    sample();
    chk("t1_we3_off", 32'(we3), 32'd0);
    chk("t1_ad3_hold", 32'(ad3), 32'd5);

    // LSU write to x0 is accepted but never written and never flags a hazard.
    next_cycle();
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_1234);
    chk1 = 5'd0;
    sample();
    chk("x0_lsu_ready", 32'(lsu_ready), 32'd1);
    next_cycle();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    sample();
    chk("x0_we3", 32'(we3), 32'd0);
    chk("x0_hz1", 32'(hz1), 32'd0);

    // Pending write to x7 against decode sources 7 and 8.
    next_cycle();
    set_in(1'b1, 5'd7, 32'hCAFE_0007, 1'b0, 5'd0, 32'd0);
    sample();
    next_cycle();
    set_in(1'b1, 5'd9, 32'h0000_0009, 1'b1, 5'd10, 32'h0000_000A);
    chk1 = 5'd7; chk2 = 5'd8;
    sample();
    chk("hz_we3", 32'(we3), 32'd1);
    chk("hz1_hit", 32'(hz1), 32'd1);
    chk("hz2_miss", 32'(hz2), 32'd0);
`ifdef WB_BYPASS_EN
    chk("byp_rd1", rd1_o, 32'hCAFE_0007);
    chk("byp_rd2", rd2_o, 32'h2222_2222);
`endif

    // Async reset while a write is pending; afterwards the ALU wins a tie.
    rst_n = 1'b0;
    #1;
    chk("arst_we3", 32'(we3), 32'd0);
    chk("arst_hz1", 32'(hz1), 32'd0);
    #1 rst_n = 1'b1;
    #1;
    chk("arst_tie_alu", 32'(alu_ready), 32'd1);
    chk("arst_tie_lsu", 32'(lsu_ready), 32'd0);

    // Random traffic; a losing requester holds its request stable.
    repeat (400) begin
      next_cycle();
      if (!alu_lost) begin
        alu_v  = ($urandom_range(0, 3) != 0);
        alu_ad = 5'($urandom_range(0, 7));
        alu_wd = $urandom;
      end
      if (!lsu_lost) begin
        lsu_v  = ($urandom_range(0, 3) != 0);
        lsu_ad = 5'($urandom_range(0, 7));
        lsu_wd = $urandom;
      end
      chk1 = 5'($urandom_range(0, 7));
      chk2 = 5'($urandom_range(0, 7));
`ifdef WB_BYPASS_EN
      rd1_i = $urandom;
      rd2_i = $urandom;
`endif
    end

    next_cycle();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    sample();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
